// File: rtl/pipe_pkg.sv
// Shared helpers for the pipeline register chain: stage-index width and the
// saturating adder used by the optional performance counters.
package pipe_pkg;

    // Width of a stage index; never narrower than one bit.
    function automatic int stage_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Saturating add on up to 64-bit operands; callers zero-extend and truncate.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: a valid bit plus payload. Kill clears valid but keeps the
// payload, hold freezes both, otherwise the slot loads from its feeder.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             hold,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Kill beats hold; hold beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= load_valid;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised in-order pipeline register chain with per-stage valid bits,
// hazard stall and flush. Stage 0 is youngest, STAGES-1 is oldest.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/kill counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall_req,
    input  logic                       flush_valid,
    input  logic [$clog2(STAGES)-1:0]  flush_stage,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*WIDTH-1:0]    stage_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]           perf_stall_cnt,
    output logic [CNT_W-1:0]           perf_kill_cnt
`endif
);

    localparam int IDX_W = stage_idx_w(STAGES);

    if (STAGES < 2) begin : g_bad_stages
        $error("pipe_stage_chain needs at least two stages");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
        $error("pipe_stage_chain counter width must be 1..64");
    end

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q    [STAGES];
    logic [STAGES-1:0] qual_stall;
    logic [STAGES-1:0] freeze;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] load_valid;
    logic [WIDTH-1:0]  load_data [STAGES];
    logic              blk;
    int                flush_lim;

    // Freeze propagates from the oldest stage toward stage 0, so a blocked or
    // stalled stage also holds everything younger than it.
    always_comb begin
        qual_stall         = stall_req & valid_q;
        blk                = valid_q[STAGES-1] & ~out_ready;
        freeze             = '0;
        freeze[STAGES-1]   = blk | qual_stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            freeze[k] = freeze[k+1] | qual_stall[k];
        end
    end

    assign in_ready = !freeze[0] && !flush_valid;

    // Flush covers stages 0..flush_stage; out-of-range indices clamp to the oldest.
    always_comb begin
        flush_lim = (int'(flush_stage) >= STAGES) ? STAGES - 1 : int'(flush_stage);
        kill      = '0;
        for (int k = 0; k < STAGES; k++) begin
            kill[k] = flush_valid && (k <= flush_lim);
        end
    end

    // Stage feeders: stage 0 from the upstream handshake, others from the stage
    // behind them; a frozen feeder hands on a bubble.
    always_comb begin
        load_valid    = '0;
        load_valid[0] = in_valid && in_ready;
        load_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            load_valid[k] = valid_q[k-1] && !freeze[k-1];
            load_data[k]  = data_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .kill       (kill[g]),
            .hold       (freeze[g]),
            .load_valid (load_valid[g]),
            .load_data  (load_data[g]),
            .valid      (valid_q[g]),
            .data       (data_q[g])
        );
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W:0] kill_num;

    // Number of live stages discarded by this cycle's flush.
    always_comb begin
        kill_num = '0;
        for (int k = 0; k < STAGES; k++) begin
            kill_num = kill_num + (IDX_W+1)'(kill[k] & valid_q[k]);
        end
    end

    // Saturating counters for refused input offers and flushed stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            perf_stall_cnt <= CNT_W'(sat_add(64'(perf_stall_cnt),
                                             64'(in_valid && !in_ready),
                                             64'(CNT_MAX)));
            perf_kill_cnt  <= CNT_W'(sat_add(64'(perf_kill_cnt),
                                             64'(kill_num),
                                             64'(CNT_MAX)));
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (STAGES=5, WIDTH=32). Accepted inputs go into a
// queue; every output transfer pops and compares the oldest entry.
module tb_pipe_stage_chain;

    localparam int STAGES = 5;
    localparam int WIDTH  = 32;
    localparam int IW     = $clog2(STAGES);

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic [STAGES-1:0]       stall_req;
    logic                    flush_valid;
    logic [IW-1:0]           flush_stage;
    logic                    out_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_kill_cnt;
`endif

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_w;

    pipe_stage_chain #(
        .STAGES(STAGES),
        .WIDTH (WIDTH),
        .CNT_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush_valid (flush_valid),
        .flush_stage (flush_stage),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Scoreboard: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got %h, required no output pending", out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL out_order: got %h, required %h", out_data, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [WIDTH-1:0] base);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            in_data = base + WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0;
        flush_valid = 1'b0; flush_stage = '0; out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (stage_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", stage_valid); end
        n_checks++; if (stage_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", stage_data); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int first;
        first = -1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c < 8) in_data = WIDTH'(c + 1);
            else in_valid = 1'b0;
            if (out_valid === 1'b1 && first < 0) first = c;
        end
        n_checks++; if (first != STAGES) begin n_fail++; $display("FAIL stream_latency: got %0d, required %0d", first, STAGES); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_stall();
        fill(32'h10);
        out_ready = 1'b1; stall_req = 5'b00100; in_valid = 1'b1; in_data = 32'h20;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
        tick();
        n_checks++; if (stage_valid !== 5'b10111) begin n_fail++; $display("FAIL stall_bubble1: got %b, required 10111", stage_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready2: got %b, required 0", in_ready); end
        tick();
        n_checks++; if (stage_valid !== 5'b00111) begin n_fail++; $display("FAIL stall_bubble2: got %b, required 00111", stage_valid); end
        n_checks++; if (stage_data[2*WIDTH +: WIDTH] !== 32'h12) begin n_fail++; $display("FAIL stall_hold: got %h, required 12", stage_data[2*WIDTH +: WIDTH]); end
        stall_req = '0;
        tick();
        in_data = 32'h21;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_flush();
`ifdef PIPE_PERF_CNT_EN
        logic [31:0] kill_before;
`endif
        fill(32'hA0);
`ifdef PIPE_PERF_CNT_EN
        kill_before = perf_kill_cnt;
`endif
        flush_valid = 1'b1; flush_stage = 3'd2; in_valid = 1'b1; in_data = 32'hEE;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
        tick();
        flush_valid = 1'b0; in_valid = 1'b0;
        repeat (3) void'(sb.pop_back());
        n_checks++; if (stage_valid !== 5'b11000) begin n_fail++; $display("FAIL flush_valid_bits: got %b, required 11000", stage_valid); end
        n_checks++; if (out_data !== 32'hA0) begin n_fail++; $display("FAIL flush_out_hold: got %h, required a0", out_data); end
`ifdef PIPE_PERF_CNT_EN
        n_checks++; if (perf_kill_cnt - kill_before !== 32'd3) begin n_fail++; $display("FAIL flush_kill_cnt: got %0d, required 3", perf_kill_cnt - kill_before); end
`endif
        out_ready = 1'b1;
        repeat (4) tick();
        n_checks++; if (sb.size() != 0 || stage_valid !== '0) begin n_fail++; $display("FAIL flush_drain: got %0d left valid %b, required 0", sb.size(), stage_valid); end
    endtask

    task automatic test_flush_oor();
        fill(32'hB0);
        flush_valid = 1'b1; flush_stage = 3'd7;
        tick();
        flush_valid = 1'b0; flush_stage = '0;
        sb.delete();
        n_checks++; if (stage_valid !== '0) begin n_fail++; $display("FAIL flush_oor: got %b, required 00000", stage_valid); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_oor_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [STAGES*WIDTH-1:0] exp_flat;
        for (int k = 0; k < STAGES; k++) exp_flat[k*WIDTH +: WIDTH] = 32'hC4 - WIDTH'(k);
        fill(32'hC0);
        in_valid = 1'b1; in_data = 32'hCC;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_data !== 32'hC0) begin n_fail++; $display("FAIL bp_out_stable: got %h, required c0", out_data); end
            n_checks++; if (stage_data !== exp_flat) begin n_fail++; $display("FAIL bp_stage_data: got %h, required %h", stage_data, exp_flat); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (7) tick();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_idle_stall();
        stall_req = '1; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_stall_ready: got %b, required 1", in_ready); end
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL qual_stall_ready: got %b, required 0", in_ready); end
        stall_req = '0;
        repeat (7) tick();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL idle_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hD0 + WIDTH'(i);
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        sb.delete();
        n_checks++; if (stage_valid !== '0 || stage_data !== '0) begin n_fail++; $display("FAIL mid_reset: got valid %b data %h, required 0", stage_valid, stage_data); end
        n_checks++; if (out_data !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_out: got data %h ready %b, required 0 and 1", out_data, in_ready); end
`ifdef PIPE_PERF_CNT_EN
        n_checks++; if (perf_kill_cnt !== '0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d, required 0", perf_kill_cnt); end
`endif
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_oor();
        test_backpressure();
        test_idle_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
